// File: rtl/instruction_buffer_pkg.sv
// Shared types and sizing for the instruction buffer: fetch width, buffer depth,
// scalar count width and the instruction packet carried from fetch to dispatch.
package instruction_buffer_pkg;

  localparam int IB_N            = 3;
  localparam int IB_SZ           = 8;
  localparam int NUM_SCALAR_BITS = $clog2(IB_N + 1);

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } INST_PACKET;

endpackage

// File: rtl/instruction_buffer_chk.sv
// Simulation-only property checker for the instruction buffer handshake counts.
// chk_en lets an environment mark cycles where over-dispatch is deliberate.
module instruction_buffer_chk
  import instruction_buffer_pkg::*;
#(
  parameter int N = IB_N
) (
  input logic                       clock,
  input logic                       reset,
  input logic                       chk_en,
  input logic [NUM_SCALAR_BITS-1:0] num_valid,
  input logic [NUM_SCALAR_BITS-1:0] ib_spots,
  input logic [NUM_SCALAR_BITS-1:0] num_dispatched
);

  localparam int SW = NUM_SCALAR_BITS;

  // Dispatch must never ask for more than the buffer presents; the RTL clamps it.
  a_dispatch_clamp: assert property (@(posedge clock) disable iff (reset || !chk_en)
    (num_dispatched <= num_valid))
    else $error("instruction_buffer: num_dispatched=%0d exceeds num_valid=%0d",
                num_dispatched, num_valid);

  a_valid_range: assert property (@(posedge clock) disable iff (reset)
    (num_valid <= SW'(N)))
    else $error("instruction_buffer: num_valid=%0d out of range", num_valid);

  a_spots_range: assert property (@(posedge clock) disable iff (reset)
    (ib_spots <= SW'(N)))
    else $error("instruction_buffer: ib_spots=%0d out of range", ib_spots);

endmodule

// File: rtl/instruction_buffer.sv
// Circular instruction FIFO between superscalar fetch and dispatch. All outputs are
// registered, so fetch/dispatch counts never reach an output combinationally.
module instruction_buffer
  import instruction_buffer_pkg::*;
#(
  parameter int N     = IB_N,
  parameter int DEPTH = IB_SZ
) (
  input  logic                       clock,
  input  logic                       reset,
  input  INST_PACKET                 fetch_packets [N],
  input  logic [NUM_SCALAR_BITS-1:0] num_fetched,
  output logic [NUM_SCALAR_BITS-1:0] ib_spots,
  output INST_PACKET                 dispatch_packets [N],
  output logic [NUM_SCALAR_BITS-1:0] num_valid,
  input  logic [NUM_SCALAR_BITS-1:0] num_dispatched,
  input  logic                       flush
);

  localparam int SW = NUM_SCALAR_BITS;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // DEPTH need not be a power of two, so pointer sums wrap by explicit compare.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [SW-1:0] inc);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(inc);
    if (sum >= (PW+1)'(DEPTH)) begin
      return PW'(sum - (PW+1)'(DEPTH));
    end else begin
      return PW'(sum);
    end
  endfunction

  INST_PACKET    mem_q  [DEPTH];
  INST_PACKET    mem_d  [DEPTH];
  INST_PACKET    disp_q [N];
  INST_PACKET    disp_d [N];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_s;
  logic [SW-1:0] spots_q, spots_d;
  logic [SW-1:0] valid_q, valid_d;
  logic [SW-1:0] enq_s, deq_s;

  // Pointer/occupancy next state; handshake sizes come only from registered counts.
  always_comb begin
    enq_s = (num_fetched > spots_q) ? spots_q : num_fetched;
    deq_s = (num_dispatched > valid_q) ? valid_q : num_dispatched;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = wrap_add(head_q, deq_s);
      tail_d  = wrap_add(tail_q, enq_s);
      count_d = count_q + CW'(enq_s) - CW'(deq_s);
    end
    free_s  = CW'(DEPTH) - count_d;
    valid_d = (count_d >= CW'(N)) ? SW'(N) : SW'(count_d);
    spots_d = (free_s >= CW'(N)) ? SW'(N) : SW'(free_s);
  end

  // Entry j takes fetch slot (j - tail) mod DEPTH when that slot is accepted.
  always_comb begin : wr_blk
    logic [PW-1:0] off;
    off = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (PW'(j) >= tail_q) begin
        off = PW'(j) - tail_q;
      end else begin
        off = PW'(j) + PW'(DEPTH) - tail_q;
      end
      if (!flush && (off < PW'(enq_s))) begin
        mem_d[j] = fetch_packets[off[IW-1:0]];
      end else begin
        mem_d[j] = mem_q[j];
      end
    end
  end

  // Next dispatch window, zero-masked past the valid count to hide stale storage.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (SW'(i) < valid_d) begin
        disp_d[i] = mem_d[wrap_add(head_d, SW'(i))];
      end else begin
        disp_d[i] = '0;
      end
    end
  end

  // Control and output registers; reset outranks flush and any enq/deq.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      spots_q <= SW'(N);
      for (int i = 0; i < N; i++) begin
        disp_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      spots_q <= spots_d;
      for (int i = 0; i < N; i++) begin
        disp_q[i] <= disp_d[i];
      end
    end
  end

  // Entry storage is deliberately not reset.
  always_ff @(posedge clock) begin
    for (int j = 0; j < DEPTH; j++) begin
      mem_q[j] <= mem_d[j];
    end
  end

  assign ib_spots         = spots_q;
  assign num_valid        = valid_q;
  assign dispatch_packets = disp_q;

endmodule

// File: tb/tb_instruction_buffer.sv
// Randomised and directed bench for instruction_buffer, checked against a queue model.
module tb_instruction_buffer;
  import instruction_buffer_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 8;
  localparam int SW    = NUM_SCALAR_BITS;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          chk_en;
  INST_PACKET    fetch_packets    [N];
  INST_PACKET    dispatch_packets [N];
  logic [SW-1:0] num_fetched, num_dispatched, ib_spots, num_valid;

  int            total = 0;
  int            bad   = 0;
  INST_PACKET    mq[$];
  logic [31:0]   next_pc = 32'h0;

  instruction_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_packets    (fetch_packets),
    .num_fetched      (num_fetched),
    .ib_spots         (ib_spots),
    .dispatch_packets (dispatch_packets),
    .num_valid        (num_valid),
    .num_dispatched   (num_dispatched),
    .flush            (flush)
  );

  instruction_buffer_chk #(.N(N)) u_chk (
    .clock          (clock),
    .reset          (reset),
    .chk_en         (chk_en),
    .num_valid      (num_valid),
    .ib_spots       (ib_spots),
    .num_dispatched (num_dispatched)
  );

  always #5 clock = ~clock;

  function automatic int exp_valid();
    return (mq.size() < N) ? mq.size() : N;
  endfunction

  function automatic int exp_spots();
    int f;
    f = DEPTH - mq.size();
    return (f < N) ? f : N;
  endfunction

  function automatic INST_PACKET exp_pkt(input int i);
    INST_PACKET z;
    z = '0;
    if (i < exp_valid()) z = mq[i];
    return z;
  endfunction

  function automatic INST_PACKET make_pkt(input logic [31:0] pc);
    INST_PACKET p;
    p.valid = 1'b1;
    p.inst  = $urandom;
    p.pc    = pc;
    p.npc   = pc + 32'd4;
    return p;
  endfunction

  // One clock of stimulus; the model applies the buffer rules on the same edge.
  task automatic drive_cycle(input int nf, input int nd, input bit fl, input bit rs);
    int pv, ps, deq, enq;
    INST_PACKET offer [N];
    pv = exp_valid();
    ps = exp_spots();
    for (int i = 0; i < N; i++) begin
      offer[i] = (i < nf) ? make_pkt(next_pc + 32'(4 * i)) : make_pkt($urandom);
      fetch_packets[i] = offer[i];
    end
    num_fetched    = SW'(nf);
    num_dispatched = SW'(nd);
    flush          = fl;
    reset          = rs;
    chk_en         = (nd <= pv);
    @(posedge clock);
    #1;
    if (rs || fl) begin
      mq.delete();
    end else begin
      deq = (nd < pv) ? nd : pv;
      repeat (deq) void'(mq.pop_front());
      enq = (nf < ps) ? nf : ps;
      for (int i = 0; i < enq; i++) mq.push_back(offer[i]);
      next_pc += 32'(4 * enq);
    end
    num_fetched    = '0;
    num_dispatched = '0;
    flush          = 1'b0;
    reset          = 1'b0;
    chk_en         = 1'b1;
  endtask

  task automatic test_reset();
    drive_cycle(0, 0, 1'b0, 1'b1);
    drive_cycle(0, 0, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      total++;
      if (num_valid !== 2'd0) begin
        bad++; $display("FAIL reset_valid cyc=%0d got=%0d exp=0", c, num_valid);
      end
      total++;
      if (ib_spots !== 2'd3) begin
        bad++; $display("FAIL reset_spots cyc=%0d got=%0d exp=3", c, ib_spots);
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (dispatch_packets[i] !== INST_PACKET'(0)) begin
          bad++; $display("FAIL reset_disp slot=%0d got=%h exp=0", i, dispatch_packets[i]);
        end
      end
      drive_cycle(0, 3, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fill();
    int exp_sp [4] = '{3, 2, 0, 0};
    int exp_nv [3] = '{3, 2, 0};
    logic [31:0] exp_hd [3] = '{32'h0C, 32'h18, 32'h00};
    drive_cycle(0, 0, 1'b0, 1'b1);
    next_pc = 32'h0;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(3, 0, 1'b0, 1'b0);
      total++;
      if (ib_spots !== SW'(exp_sp[c])) begin
        bad++; $display("FAIL fill_spots cyc=%0d got=%0d exp=%0d", c, ib_spots, exp_sp[c]);
      end
      total++;
      if (num_valid !== 2'd3 || dispatch_packets[0].pc !== 32'h0) begin
        bad++; $display("FAIL fill_head cyc=%0d got nv=%0d pc=%h exp nv=3 pc=0", c,
                        num_valid, dispatch_packets[0].pc);
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive_cycle(0, 3, 1'b0, 1'b0);
      total++;
      if (num_valid !== SW'(exp_nv[c])) begin
        bad++; $display("FAIL drain_valid cyc=%0d got=%0d exp=%0d", c, num_valid, exp_nv[c]);
      end
      total++;
      if (exp_nv[c] > 0 && dispatch_packets[0].pc !== exp_hd[c]) begin
        bad++; $display("FAIL drain_head cyc=%0d got=%h exp=%h", c, dispatch_packets[0].pc, exp_hd[c]);
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (dispatch_packets[i] !== exp_pkt(i)) begin
          bad++; $display("FAIL drain_pkt cyc=%0d slot=%0d got pc=%h exp pc=%h", c, i,
                          dispatch_packets[i].pc, exp_pkt(i).pc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] head_pc;
    drive_cycle(0, 0, 1'b0, 1'b1);
    head_pc = next_pc;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(3, 3, 1'b0, 1'b0);
      total++;
      if (num_valid !== 2'd3 || ib_spots !== 2'd3) begin
        bad++; $display("FAIL wrap_counts cyc=%0d got nv=%0d sp=%0d exp 3/3", c, num_valid, ib_spots);
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (dispatch_packets[i].pc !== head_pc + 32'(4 * i) || dispatch_packets[i] !== exp_pkt(i)) begin
          bad++; $display("FAIL wrap_order cyc=%0d slot=%0d got pc=%h exp pc=%h", c, i,
                          dispatch_packets[i].pc, head_pc + 32'(4 * i));
        end
      end
      head_pc += 32'd12;
    end
  endtask

  task automatic test_simultaneous();
    INST_PACKET old3;
    drive_cycle(0, 0, 1'b0, 1'b1);
    drive_cycle(3, 0, 1'b0, 1'b0);
    drive_cycle(2, 0, 1'b0, 1'b0);
    old3 = mq[3];
    drive_cycle(3, 3, 1'b0, 1'b0);
    total++;
    if (num_valid !== 2'd3 || ib_spots !== 2'd3) begin
      bad++; $display("FAIL simul_counts got nv=%0d sp=%0d exp 3/3", num_valid, ib_spots);
    end
    total++;
    if (dispatch_packets[0] !== old3) begin
      bad++; $display("FAIL simul_head got pc=%h exp pc=%h", dispatch_packets[0].pc, old3.pc);
    end
    drive_cycle(0, 3, 1'b0, 1'b0);
    total++;
    if (num_valid !== 2'd2 || dispatch_packets[1] !== exp_pkt(1)) begin
      bad++; $display("FAIL simul_count5 got nv=%0d exp=2", num_valid);
    end
  endtask

  task automatic test_flush_and_midreset();
    for (int k = 0; k < 2; k++) begin
      drive_cycle(0, 0, 1'b0, 1'b1);
      drive_cycle(3, 0, 1'b0, 1'b0);
      drive_cycle(3, 0, 1'b0, 1'b0);
      if (k == 0) drive_cycle(3, 0, 1'b1, 1'b0);
      else        drive_cycle(0, 2, 1'b0, 1'b1);
      total++;
      if (num_valid !== 2'd0 || ib_spots !== 2'd3) begin
        bad++; $display("FAIL squash%0d_counts got nv=%0d sp=%0d exp 0/3", k, num_valid, ib_spots);
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (dispatch_packets[i] !== INST_PACKET'(0)) begin
          bad++; $display("FAIL squash%0d_disp slot=%0d got pc=%h exp=0", k, i, dispatch_packets[i].pc);
        end
      end
      drive_cycle(2, 0, 1'b0, 1'b0);
      total++;
      if (num_valid !== 2'd2 || dispatch_packets[0] !== exp_pkt(0)) begin
        bad++; $display("FAIL squash%0d_refill got nv=%0d pc=%h exp nv=2 pc=%h", k, num_valid,
                        dispatch_packets[0].pc, exp_pkt(0).pc);
      end
    end
  endtask

  task automatic test_random();
    int nf, nd;
    bit fl, rs;
    drive_cycle(0, 0, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      nf = $urandom_range(0, 3);
      nd = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, exp_valid());
      fl = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 59) == 0);
      drive_cycle(nf, nd, fl, rs);
      total++;
      if (num_valid !== SW'(exp_valid()) || ib_spots !== SW'(exp_spots())) begin
        bad++; $display("FAIL rand_counts cyc=%0d got nv=%0d sp=%0d exp nv=%0d sp=%0d", c,
                        num_valid, ib_spots, exp_valid(), exp_spots());
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (dispatch_packets[i] !== exp_pkt(i)) begin
          bad++; $display("FAIL rand_pkt cyc=%0d slot=%0d got pc=%h exp pc=%h", c, i,
                          dispatch_packets[i].pc, exp_pkt(i).pc);
        end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    chk_en         = 1'b1;
    num_fetched    = '0;
    num_dispatched = '0;
    for (int i = 0; i < N; i++) fetch_packets[i] = '0;
    test_reset();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flush_and_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
